jtflane_pcm_fetch: RTL and testbench



---
 rtl/jtflane_pcm_fetch.sv | 143 ++++++++++++++
 tb/tb_jtflane_pcm_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtflane_pcm_fetch.sv
// jtflane_pcm_fetch
//   Adapter between one K007232 PCM channel address bus and one 8-bit SDRAM ROM slot.
//   Keeps the byte for the current channel address and prefetches the next sequential
//   byte, so linear sample playback does not see SDRAM latency.
//
// Parameters
//   AW        address width of channel and slot (17, or 19 for PCM1 channels)
//   PREFETCH  1: fetch addr+1 after each capture/promote; 0: fetch on demand only
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   cen                chip clock enable; snd_addr is only looked at when cen=1
//   snd_addr           byte address requested by the PCM channel
//   snd_dout, snd_ok   registered byte for the last sampled address and its valid flag
//   rom_addr, rom_cs   request to the ROM slot; cs held until capture or retarget
//   rom_data, rom_ok   ROM slot response
//   miss_cnt           (JTFLANE_PCM_STATS_EN only) saturating count of cen-sampled misses
//
// Build option
//   `define JTFLANE_PCM_STATS_EN adds the miss_cnt output and its counter.
module jtflane_pcm_fetch #(
   parameter int unsigned AW       = 17,
   parameter int unsigned PREFETCH = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic [AW-1:0] snd_addr,
   output logic [7:0]    snd_dout,
   output logic          snd_ok,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok
`ifdef JTFLANE_PCM_STATS_EN
   ,
   output logic [15:0]   miss_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StFetchCur, StFetchNxt} state_e;

   state_e        state;
   logic [AW-1:0] req_addr;
   logic [AW-1:0] cur_addr, nxt_addr;
   logic [7:0]    cur_data, nxt_data;
   logic          cur_vld, nxt_vld;
   logic          guard;
   logic          cs_q;

   logic hit, promote, wait_cur, miss, qok;

   assign hit      = cur_vld && (snd_addr == cur_addr);
   assign promote  = !hit && nxt_vld && (snd_addr == nxt_addr);
   // The channel re-presenting the address already being fetched is not a new miss;
   // retargeting here would restart the guard and could starve the fetch.
   assign wait_cur = (state == StFetchCur) && (snd_addr == req_addr);
   assign miss     = cen && !hit && !promote && !wait_cur;
   // The slot may still hold ok from the previous request for one cycle.
   assign qok      = rom_ok && !guard;

   assign rom_addr = req_addr;
   assign rom_cs   = cs_q;
   assign snd_dout = cur_data;
   assign snd_ok   = cur_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         req_addr <= '0;
         cur_addr <= '0;
         cur_data <= '0;
         cur_vld  <= 1'b0;
         nxt_addr <= '0;
         nxt_data <= '0;
         nxt_vld  <= 1'b0;
         guard    <= 1'b0;
         cs_q     <= 1'b0;
      end else begin
         guard <= 1'b0;
         if (miss) begin
            // Miss beats any ROM data arriving in the same cycle.
            cur_vld  <= 1'b0;
            nxt_vld  <= 1'b0;
            state    <= StFetchCur;
            req_addr <= snd_addr;
            cs_q     <= 1'b1;
            guard    <= 1'b1;
         end else if (cen && promote) begin
            // Only reachable from StIdle: nxt_vld is cleared whenever a fetch starts.
            cur_addr <= nxt_addr;
            cur_data <= nxt_data;
            cur_vld  <= 1'b1;
            nxt_vld  <= 1'b0;
            if (PREFETCH != 0) begin
               state    <= StFetchNxt;
               req_addr <= nxt_addr + AW'(1);
               cs_q     <= 1'b1;
               guard    <= 1'b1;
            end
         end else begin
            case (state)
               StFetchCur: begin
                  if (qok) begin
                     cur_data <= rom_data;
                     cur_addr <= req_addr;
                     cur_vld  <= 1'b1;
                     if (PREFETCH != 0) begin
                        state    <= StFetchNxt;
                        req_addr <= req_addr + AW'(1);
                        guard    <= 1'b1;
                     end else begin
                        state <= StIdle;
                        cs_q  <= 1'b0;
                     end
                  end
               end
               StFetchNxt: begin
                  if (qok) begin
                     nxt_data <= rom_data;
                     nxt_addr <= req_addr;
                     nxt_vld  <= 1'b1;
                     cs_q     <= 1'b0;
                     state    <= StIdle;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef JTFLANE_PCM_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_cnt <= '0;
      end else if (miss && (miss_cnt != 16'hFFFF)) begin
         miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_jtflane_pcm_fetch.sv
// Bench for jtflane_pcm_fetch (AW=17, PREFETCH=1). A slot responder answers ROM requests
// with registered data (one cycle behind rom_addr) and random ok latency, or holds ok
// high constantly in stale mode. Expected bytes come from a ROM content function and a
// transaction-level model that only remembers the last sampled address.
module tb_jtflane_pcm_fetch;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cen = 1'b0;
   logic [AW-1:0] snd_addr = '0;
   logic [7:0]    snd_dout;
   logic          snd_ok;
   logic [AW-1:0] rom_addr;
   logic          rom_cs;
   logic [7:0]    rom_data = 8'd0;
   logic          rom_ok = 1'b0;
`ifdef JTFLANE_PCM_STATS_EN
   logic [15:0]   miss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic          stale_mode = 1'b0;
   logic [AW-1:0] last_addr = '0;
   logic          last_cs = 1'b0;
   int            dly = 0;

   logic [AW-1:0] m_addr;
   logic          m_vld;
   int            m_miss;

   jtflane_pcm_fetch #(.AW(AW), .PREFETCH(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .snd_addr (snd_addr),
      .snd_dout (snd_dout),
      .snd_ok   (snd_ok),
      .rom_addr (rom_addr),
      .rom_cs   (rom_cs),
      .rom_data (rom_data),
      .rom_ok   (rom_ok)
`ifdef JTFLANE_PCM_STATS_EN
      ,
      .miss_cnt (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem(input logic [AW-1:0] a);
      logic [7:0] lo;
      if (a == 17'h00100) return 8'h5A;
      if (a == 17'h00101) return 8'h77;
      lo = a[7:0] * 8'd29;
      return lo ^ a[15:8] ^ {7'd0, a[16]} ^ 8'hC3;
   endfunction

   // Slot responder: data lags the address by one cycle, so ok seen right after an
   // address change pairs with the previous address's byte.
   always @(posedge clk) begin
      rom_data  <= mem(rom_addr);
      last_addr <= rom_addr;
      last_cs   <= rom_cs;
      if (stale_mode) begin
         rom_ok <= 1'b1;
      end else if (!rom_cs || !last_cs || rom_addr != last_addr) begin
         rom_ok <= 1'b0;
         dly    <= int'($urandom_range(2, 0));
      end else if (dly == 0) begin
         rom_ok <= 1'b1;
      end else begin
         dly <= dly - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic [AW-1:0] a);
      cen      = 1'b1;
      snd_addr = a;
      @(negedge clk);
      cen      = 1'b0;
   endtask

   task automatic wait_ok(input string tag);
      for (int i = 0; i < 24; i++) begin
         if (snd_ok === 1'b1) break;
         @(negedge clk);
      end
      check(tag, 32'(snd_ok), 32'd1);
   endtask

   task automatic wait_cs_low(input string tag);
      for (int i = 0; i < 24; i++) begin
         if (rom_cs === 1'b0) break;
         @(negedge clk);
      end
      check(tag, 32'(rom_cs), 32'd0);
   endtask

   // One channel access followed by enough idle time for the prefetch to finish.
   task automatic access(input logic [AW-1:0] a);
      logic [AW-1:0] a1, nx;
      logic is_hit, is_prom;
      a1      = a + AW'(1);
      nx      = m_addr + AW'(1);
      is_hit  = m_vld && (a == m_addr);
      is_prom = m_vld && !is_hit && (a == nx);
      sample(a);
      if (is_hit) begin
         check("hit_ok", 32'(snd_ok), 32'd1);
         check("hit_dout", 32'(snd_dout), 32'(mem(a)));
         check("hit_cs", 32'(rom_cs), 32'd0);
      end else if (is_prom) begin
         check("prom_ok", 32'(snd_ok), 32'd1);
         check("prom_dout", 32'(snd_dout), 32'(mem(a)));
         check("prom_cs", 32'(rom_cs), 32'd1);
         check("prom_addr", 32'(rom_addr), 32'(a1));
      end else begin
         m_miss++;
         check("miss_ok", 32'(snd_ok), 32'd0);
         check("miss_addr", 32'(rom_addr), 32'(a));
         check("miss_cs", 32'(rom_cs), 32'd1);
         wait_ok("miss_lat");
         check("miss_dout", 32'(snd_dout), 32'(mem(a)));
         check("miss_pf_addr", 32'(rom_addr), 32'(a1));
      end
      m_addr = a;
      m_vld  = 1'b1;
      repeat (16) @(negedge clk);
      check("idle_cs", 32'(rom_cs), 32'd0);
      check("idle_addr", 32'(rom_addr), 32'(a1));
      check("idle_dout", 32'(snd_dout), 32'(mem(a)));
   endtask

   initial begin
      logic [AW-1:0] a;
      int            r;
      m_addr = '0;
      m_vld  = 1'b0;
      m_miss = 0;

      repeat (3) @(negedge clk);
      check("rst_ok", 32'(snd_ok), 32'd0);
      check("rst_dout", 32'(snd_dout), 32'd0);
      check("rst_cs", 32'(rom_cs), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // First fetch and its prefetch
      sample(17'h00100);
      check("t1_ok_low", 32'(snd_ok), 32'd0);
      check("t1_addr", 32'(rom_addr), 32'h100);
      check("t1_cs", 32'(rom_cs), 32'd1);
      wait_ok("t1_lat");
      check("t1_dout", 32'(snd_dout), 32'h5A);
      check("t1_pf_addr", 32'(rom_addr), 32'h101);
      check("t1_pf_cs", 32'(rom_cs), 32'd1);
      wait_cs_low("t1_pf_done");
      m_miss = 1;

      // Promote: snd_ok never drops, next prefetch starts
      sample(17'h00101);
      check("t2_ok", 32'(snd_ok), 32'd1);
      check("t2_dout", 32'(snd_dout), 32'h77);
      check("t2_addr", 32'(rom_addr), 32'h102);
      check("t2_cs", 32'(rom_cs), 32'd1);

      // Jump while the 0x102 prefetch is in flight
      sample(17'h0F000);
      m_miss++;
      check("t4_ok", 32'(snd_ok), 32'd0);
      check("t4_addr", 32'(rom_addr), 32'h0F000);
      check("t4_cs", 32'(rom_cs), 32'd1);
      wait_ok("t4_lat");
      check("t4_dout", 32'(snd_dout), 32'(mem(17'h0F000)));
      repeat (16) @(negedge clk);
      check("t4_idle_cs", 32'(rom_cs), 32'd0);

      // Stale ok held high: guard cycle ignored, minimum miss latency
      stale_mode = 1'b1;
      @(negedge clk);
      sample(17'h02345);
      m_miss++;
      check("t3_c1_ok", 32'(snd_ok), 32'd0);
      @(negedge clk);
      check("t3_c2_ok", 32'(snd_ok), 32'd0);
      @(negedge clk);
      check("t3_c3_ok", 32'(snd_ok), 32'd1);
      check("t3_c3_dout", 32'(snd_dout), 32'(mem(17'h02345)));
      check("t3_c3_addr", 32'(rom_addr), 32'h02346);
      @(negedge clk);
      check("t3_c4_cs", 32'(rom_cs), 32'd1);
      @(negedge clk);
      check("t3_c5_cs", 32'(rom_cs), 32'd0);
      sample(17'h02346);
      check("t3_prom_ok", 32'(snd_ok), 32'd1);
      check("t3_prom_dout", 32'(snd_dout), 32'(mem(17'h02346)));
      stale_mode = 1'b0;
      repeat (16) @(negedge clk);
      m_addr = 17'h02346;
      m_vld  = 1'b1;

      // Address wrap on prefetch
      access(17'h1FFFF);
      access(17'h00000);

      // Asynchronous reset in the middle of a fetch
      sample(17'h00500);
      m_miss++;
      #2 rst_n = 1'b0;
      #1;
      check("arst_cs", 32'(rom_cs), 32'd0);
      check("arst_ok", 32'(snd_ok), 32'd0);
      check("arst_addr", 32'(rom_addr), 32'd0);
      check("arst_dout", 32'(snd_dout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      m_vld  = 1'b0;
      m_miss = 0;

      // Three misses and two promotes
      access(17'h00300);
      access(17'h00301);
      access(17'h00800);
      access(17'h00801);
      access(17'h00050);
`ifdef JTFLANE_PCM_STATS_EN
      check("stats_3", 32'(miss_cnt), 32'd3);
`endif

      // Randomized accesses against the model
      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(3, 0));
         case (r)
            0:       a = m_addr;
            1:       a = m_addr + AW'(1);
            2:       a = 17'h1FFFF;
            default: a = AW'($urandom);
         endcase
         access(a);
      end
`ifdef JTFLANE_PCM_STATS_EN
      check("stats_rand", 32'(miss_cnt), 32'(m_miss));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
